// File: rtl/apb_pkg.sv
// Shared types for the APB requester: FSM state encoding and the captured response record.
package apb_pkg;

  localparam int APB_MAX_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_req_state_e;

  typedef struct packed {
    logic [APB_MAX_DATA_W-1:0] rdata;
    logic                      err;
  } apb_rsp_t;

endpackage

// File: rtl/apb_addr_decoder.sv
// Maps a request address onto a one-hot completer select inside the window starting at BASE_ADDR.
module apb_addr_decoder #(
  parameter int                ADDR_W      = 32,
  parameter int                NUM_SLV     = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h1000_0000,
  parameter int                REGION_BITS = 12
) (
  input  logic [ADDR_W-1:0]  addr_i,
  output logic [NUM_SLV-1:0] sel_o,
  output logic               hit_o
);

  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] index;

  assign offset = addr_i - BASE_ADDR;
  assign index  = offset >> REGION_BITS;
  assign hit_o  = (addr_i >= BASE_ADDR) && (index < ADDR_W'(NUM_SLV));

  always_comb begin
    sel_o = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (hit_o && (index == ADDR_W'(i))) sel_o[i] = 1'b1;
    end
  end

endmodule

// File: rtl/apb_requester_param.sv
// Single-outstanding APB requester bridging a valid/ready front end onto NUM_SLV completers.
// Optional ACCESS-phase timeout when APB_REQ_TIMEOUT_EN is defined.
//
// state     | meaning
// ST_IDLE   | req_ready high, waiting for a request to latch and decode
// ST_SETUP  | one-cycle APB setup phase, PSEL high, PENABLE low
// ST_ACCESS | PENABLE high, waiting for PREADY (or timeout)
// ST_RESP   | rsp_valid high until rsp_ready
module apb_requester_param
  import apb_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                NUM_SLV     = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h1000_0000,
  parameter int                REGION_BITS = 12,
  parameter int                TIMEOUT_CYC = 256,
  localparam int               STRB_W      = DATA_W / 8
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  output logic [ADDR_W-1:0]  PADDR,
  output logic               PWRITE,
  output logic               PENABLE,
  output logic [DATA_W-1:0]  PWDATA,
  output logic [STRB_W-1:0]  PSTRB,
  output logic [NUM_SLV-1:0] PSEL,
  input  logic               PREADY,
  input  logic [DATA_W-1:0]  PRDATA,
  input  logic               PSLVERR,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [DATA_W-1:0]  req_wdata,
  input  logic [STRB_W-1:0]  req_strb,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_rdata,
  output logic               rsp_err
);

  if (DATA_W != 8 && DATA_W != 16 && DATA_W != 32) begin : g_bad_data_w
    $error("DATA_W must be 8, 16 or 32");
  end
  if (NUM_SLV < 1 || NUM_SLV > 16) begin : g_bad_num_slv
    $error("NUM_SLV must be in 1..16");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  apb_req_state_e     state_q;
  logic [ADDR_W-1:0]  paddr_q;
  logic               pwrite_q;
  logic               penable_q;
  logic [DATA_W-1:0]  pwdata_q;
  logic [STRB_W-1:0]  pstrb_q;
  logic [NUM_SLV-1:0] psel_q;
  logic               rsp_valid_q;
  apb_rsp_t           rsp_q;

  logic [NUM_SLV-1:0] dec_sel;
  logic               dec_hit;

  apb_addr_decoder #(
    .ADDR_W      (ADDR_W),
    .NUM_SLV     (NUM_SLV),
    .BASE_ADDR   (BASE_ADDR),
    .REGION_BITS (REGION_BITS)
  ) u_dec (
    .addr_i (req_addr),
    .sel_o  (dec_sel),
    .hit_o  (dec_hit)
  );

`ifdef APB_REQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] to_cnt_q;
  logic             to_expired;

  assign to_expired = (to_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      to_cnt_q <= '0;
    end else if (state_q == ST_ACCESS && !PREADY && !to_expired) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end else begin
      to_cnt_q <= '0;
    end
  end
`else
  logic to_expired;
  assign to_expired = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= ST_IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      penable_q   <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      psel_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            paddr_q  <= req_addr;
            pwrite_q <= req_write;
            pwdata_q <= req_wdata;
            pstrb_q  <= req_write ? req_strb : '0;
            if (dec_hit) begin
              psel_q  <= dec_sel;
              state_q <= ST_SETUP;
            end else begin
              // Unmapped: answer immediately with an error, never touch the bus.
              rsp_q       <= '{rdata: '0, err: 1'b1};
              rsp_valid_q <= 1'b1;
              state_q     <= ST_RESP;
            end
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (PREADY) begin
            rsp_q.rdata <= pwrite_q ? '0 : APB_MAX_DATA_W'(PRDATA);
            rsp_q.err   <= PSLVERR;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else if (to_expired) begin
            rsp_q       <= '{rdata: '0, err: 1'b1};
            psel_q      <= '0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PENABLE   = penable_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;
  assign PSEL      = psel_q;
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_q.rdata[DATA_W-1:0];
  assign rsp_err   = rsp_q.err;

endmodule
